pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the architectural program counter and sequences instruction fetch for the single-issue MIPS core. Each cycle it selects the next PC: sequential PC+4, branch target, jump target, jump-register target, or exception vector. It also handles pipeline stall, halt/resume, misaligned-target trapping and EPC capture. It replaces the free-running PC register in front of the PC adder and drives the instruction-memory address and the IF/ID flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, PC loaded on exception or misaligned target

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high; forces reset state immediately
Stall  input  1  hazard unit hold; PC and state frozen this cycle
BranchTaken  input  1  conditional branch resolved taken
BranchTarget  input  32  branch destination
Jump  input  1  J/JAL decoded
JumpTarget  input  32  pseudo-direct jump destination
JumpReg  input  1  JR/JALR decoded
JumpRegTarget  input  32  register-sourced destination
Exception  input  1  exception raised by a later stage
ExcPC  input  32  PC of faulting instruction
Halt  input  1  enter HALT (syscall/break)
Resume  input  1  leave HALT
PC  output  32  current fetch address (IMem address)
PCPlus4  output  32  PC + 4, for link register
FetchValid  output  1  PC is a valid fetch this cycle
Flush  output  1  squash instruction in IF/ID
EPC  output  32  exception program counter
AddrErr  output  1  one-cycle pulse: misaligned redirect trapped
Halted  output  1  high while in HALT

Behaviour:
- Reset (async, any time incl. mid-redirect): PC=RESET_PC, EPC=0, Flush=0, AddrErr=0, state=RUN; Halted=0; FetchValid=1 on the first cycle after deassertion.
- PCPlus4 is combinational PC+32'h4 and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- States: RUN, HALT.
- RUN, Stall=0: next PC by fixed priority:
  - Exception: EPC<=ExcPC, PC<=EXC_VECTOR.
  - JumpReg: PC<=JumpRegTarget.
  - Jump: PC<=JumpTarget.
  - BranchTaken: PC<=BranchTarget.
  - Otherwise: PC<=PCPlus4.
- Any non-sequential selection is a redirect; Flush is registered, high the cycle after the redirect edge, for exactly 1 cycle.
- Misaligned redirect (selected target[1:0]!=0, exception not asserted): PC<=EXC_VECTOR, EPC<=offending target, AddrErr=1 next cycle (registered, 1 cycle), Flush=1.
- EXC_VECTOR is never checked for alignment.
- RUN, Stall=1: PC, EPC, state held; Flush=0, AddrErr=0.
- Exception overrides Stall: an Exception with Stall=1 is still taken.
- Halt=1 in RUN (no Exception): PC<=PCPlus4 so that Resume continues after the syscall; state<=HALT.
- Exception with Halt: the exception wins, state stays RUN.
- HALT: FetchValid=0, Halted=1, PC held; all redirect inputs except Exception ignored.
  - Resume=1: state<=RUN, with FetchValid=1 the next cycle.
  - Exception in HALT: exception taken, state<=RUN.
- FetchValid=1 in RUN, including stall cycles; the memory re-reads the same PC.
- No combinational path from redirect inputs to PC; latency from redirect input to new PC is 1 cycle.

Test Plan:
- Reset -> RESET_PC=0 with no stimulus for 4 cycles -> PC sequence 0,4,8,C; Flush=0; FetchValid=1.
- PC=0x10, BranchTaken=1 with BranchTarget=0x40 for one cycle -> next PC=0x40; Flush=1 for one cycle; then 0x44.
- Jump=1 (0x100), JumpReg=1 (0x200) and BranchTaken=1 (0x300) in the same cycle -> PC=0x200.
- Stall=1 for 3 cycles at PC=0x20 -> PC=0x20 throughout; then Stall=0 -> 0x24.
- Exception=1 with ExcPC=0x24 while Stall=1 -> PC=0x80000180, EPC=0x24, Flush pulse.
- JumpRegTarget=0x102 with JumpReg=1 -> PC=0x80000180, EPC=0x102, AddrErr and Flush pulse for one cycle each.
- Halt at PC=0x30 -> Halted=1, FetchValid=0, PC=0x34 held.
- Resume -> PC sequence 0x34, 0x38.
- Wrap: force PC=0xFFFFFFFC via jump -> next PC=0x00000000.
- Reset asserted mid-cycle during HALT -> PC=RESET_PC and Halted=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: picks the next fetch address each cycle and
// handles stall, halt/resume, exception entry and misaligned-redirect trapping.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    input  logic        Exception,
    input  logic [31:0] ExcPC,
    input  logic        Halt,
    input  logic        Resume,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        Flush,
    output logic [31:0] EPC,
    output logic        AddrErr,
    output logic        Halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_epc, w_epc_nxt;
    logic        r_flush, w_flush_nxt;
    logic        r_addr_err, w_addr_err_nxt;
    logic        w_redirect;
    logic [31:0] w_target;

    assign PCPlus4 = r_pc + 32'h4;

    // Redirect source priority below exception: JR, then J, then taken branch.
    always_comb begin
        w_redirect = 1'b1;
        w_target   = PCPlus4;
        if (JumpReg)          w_target = JumpRegTarget;
        else if (Jump)        w_target = JumpTarget;
        else if (BranchTaken) w_target = BranchTarget;
        else                  w_redirect = 1'b0;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_epc_nxt      = r_epc;
        w_flush_nxt    = 1'b0;
        w_addr_err_nxt = 1'b0;
        if (Exception) begin
            // Taken in either state and even while stalled.
            w_pc_nxt    = EXC_VECTOR;
            w_epc_nxt   = ExcPC;
            w_flush_nxt = 1'b1;
            w_state_nxt = RUN;
        end else if (r_state == HALT) begin
            if (Resume) w_state_nxt = RUN;
        end else if (!Stall) begin
            if (Halt) begin
                w_pc_nxt    = PCPlus4;
                w_state_nxt = HALT;
            end else if (w_redirect) begin
                w_flush_nxt = 1'b1;
                if (w_target[1:0] != 2'b00) begin
                    w_pc_nxt       = EXC_VECTOR;
                    w_epc_nxt      = w_target;
                    w_addr_err_nxt = 1'b1;
                end else begin
                    w_pc_nxt = w_target;
                end
            end else begin
                w_pc_nxt = PCPlus4;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_epc      <= 32'h0;
            r_flush    <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_epc      <= w_epc_nxt;
            r_flush    <= w_flush_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

    assign PC         = r_pc;
    assign EPC        = r_epc;
    assign Flush      = r_flush;
    assign AddrErr    = r_addr_err;
    assign Halted     = (r_state == HALT);
    assign FetchValid = (r_state == RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed PC/EPC/Flush/AddrErr sequences.
module tb_pc_sequencer;

    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0, BranchTaken = 1'b0, Jump = 1'b0, JumpReg = 1'b0;
    logic        Exception = 1'b0, Halt = 1'b0, Resume = 1'b0;
    logic [31:0] BranchTarget = '0, JumpTarget = '0, JumpRegTarget = '0, ExcPC = '0;
    logic [31:0] PC, PCPlus4, EPC;
    logic        FetchValid, Flush, AddrErr, Halted;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .JumpReg(JumpReg), .JumpRegTarget(JumpRegTarget),
        .Exception(Exception), .ExcPC(ExcPC),
        .Halt(Halt), .Resume(Resume),
        .PC(PC), .PCPlus4(PCPlus4), .FetchValid(FetchValid), .Flush(Flush),
        .EPC(EPC), .AddrErr(AddrErr), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        Stall = 0; BranchTaken = 0; Jump = 0; JumpReg = 0;
        Exception = 0; Halt = 0; Resume = 0;
    endtask

    initial begin
        #3;
        chk("rst_pc", PC, 32'h0);
        chk("rst_epc", EPC, 32'h0);
        chk("rst_flush", {31'b0, Flush}, 32'h0);
        chk("rst_aerr", {31'b0, AddrErr}, 32'h0);
        chk("rst_halted", {31'b0, Halted}, 32'h0);
        #9 Reset = 0;  // t=12, between edges
        chk("rst_fv", {31'b0, FetchValid}, 32'h1);

        step(); chk("seq4", PC, 32'h4);
        step(); chk("seq8", PC, 32'h8);
        step(); chk("seqC", PC, 32'hC);
        chk("seq_flush", {31'b0, Flush}, 32'h0);
        chk("pcplus4", PCPlus4, 32'h10);
        step(); chk("seq10", PC, 32'h10);

        // Taken branch
        BranchTaken = 1; BranchTarget = 32'h40;
        step(); clr();
        chk("br_pc", PC, 32'h40);
        chk("br_flush", {31'b0, Flush}, 32'h1);
        step();
        chk("br_pc2", PC, 32'h44);
        chk("br_flush2", {31'b0, Flush}, 32'h0);

        // Priority: JR over J over branch
        Jump = 1; JumpTarget = 32'h100; JumpReg = 1; JumpRegTarget = 32'h200;
        BranchTaken = 1; BranchTarget = 32'h300;
        step(); clr();
        chk("prio_pc", PC, 32'h200);

        // Stall at 0x20, with a branch ignored during the stall
        Jump = 1; JumpTarget = 32'h20;
        step(); clr();
        chk("j20", PC, 32'h20);
        Stall = 1; BranchTaken = 1; BranchTarget = 32'h40;
        step(); BranchTaken = 0;
        chk("stall1", PC, 32'h20);
        chk("stall_flush", {31'b0, Flush}, 32'h0);
        step(); chk("stall2", PC, 32'h20);
        step(); chk("stall3", PC, 32'h20);
        chk("stall_fv", {31'b0, FetchValid}, 32'h1);
        Stall = 0;
        step(); chk("stall_rel", PC, 32'h24);

        // Exception overrides stall
        Stall = 1; Exception = 1; ExcPC = 32'h24;
        step(); clr();
        chk("exc_pc", PC, EXC);
        chk("exc_epc", EPC, 32'h24);
        chk("exc_flush", {31'b0, Flush}, 32'h1);
        step();
        chk("exc_pc2", PC, EXC + 32'h4);
        chk("exc_flush2", {31'b0, Flush}, 32'h0);

        // Misaligned JR target traps
        JumpReg = 1; JumpRegTarget = 32'h102;
        step(); clr();
        chk("mis_pc", PC, EXC);
        chk("mis_epc", EPC, 32'h102);
        chk("mis_aerr", {31'b0, AddrErr}, 32'h1);
        chk("mis_flush", {31'b0, Flush}, 32'h1);
        step();
        chk("mis_aerr2", {31'b0, AddrErr}, 32'h0);
        chk("mis_flush2", {31'b0, Flush}, 32'h0);
        chk("mis_pc2", PC, EXC + 32'h4);

        // Halt at 0x30
        Jump = 1; JumpTarget = 32'h30;
        step(); clr();
        chk("j30", PC, 32'h30);
        Halt = 1;
        step(); clr();
        chk("halt_pc", PC, 32'h34);
        chk("halt_h", {31'b0, Halted}, 32'h1);
        chk("halt_fv", {31'b0, FetchValid}, 32'h0);
        Jump = 1; JumpTarget = 32'h500;
        step(); clr();
        chk("halt_hold", PC, 32'h34);
        chk("halt_h2", {31'b0, Halted}, 32'h1);
        Resume = 1;
        step(); clr();
        chk("res_pc", PC, 32'h34);
        chk("res_h", {31'b0, Halted}, 32'h0);
        chk("res_fv", {31'b0, FetchValid}, 32'h1);
        step(); chk("res_pc2", PC, 32'h38);

        // Wrap
        Jump = 1; JumpTarget = 32'hFFFF_FFFC;
        step(); clr();
        chk("wrap_pc", PC, 32'hFFFF_FFFC);
        chk("wrap_p4", PCPlus4, 32'h0);
        step(); chk("wrap_pc2", PC, 32'h0);

        // Exception while halted
        Halt = 1;
        step(); clr();
        chk("h2_pc", PC, 32'h4);
        Exception = 1; ExcPC = 32'h4;
        step(); clr();
        chk("hexc_pc", PC, EXC);
        chk("hexc_epc", EPC, 32'h4);
        chk("hexc_h", {31'b0, Halted}, 32'h0);

        // Async reset mid-cycle while halted
        Halt = 1;
        step(); clr();
        chk("h3_h", {31'b0, Halted}, 32'h1);
        #2 Reset = 1;
        #1;
        chk("areset_pc", PC, 32'h0);
        chk("areset_h", {31'b0, Halted}, 32'h0);
        chk("areset_epc", EPC, 32'h0);
        #2 Reset = 0;
        step(); chk("post_rst", PC, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
